// File: rtl/shift_left_seq.sv
// shift_left_seq: sequential left shifter, one binary stage of shamt per cycle (MSB stage first).
// Define SHIFT_LEFT_SEQ_ROTATE_EN to make in_rotate select rotate-left instead of fill.
module shift_left_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_fill,
    input  logic               in_rotate,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    localparam int KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d, out_data_q, out_data_d, stage, low;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [KW-1:0]      k_q, k_d;
    logic               fill_q, fill_d, rot_q, rot_d;
    logic [SHAMT_W:0]   amt;

    // One stage: shift by 2^k, refilling the vacated low bits.
    always_comb begin
        amt = (SHAMT_W+1)'(1) << k_q;
        low = fill_q ? ~({WIDTH{1'b1}} << amt) : '0;
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
        if (rot_q) low = data_q >> ((SHAMT_W+1)'(WIDTH) - amt);
`endif
        stage = shamt_q[k_q] ? ((data_q << amt) | low) : data_q;
    end

`ifndef SHIFT_LEFT_SEQ_ROTATE_EN
    logic unused_rot;
    assign unused_rot = rot_q;
`endif

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        out_data_d = out_data_q;
        shamt_d    = shamt_q;
        fill_d     = fill_q;
        rot_d      = rot_q;
        k_d        = k_q;
        case (state_q)
            IDLE: if (in_valid) begin
                data_d  = in_data;
                shamt_d = in_shamt;
                fill_d  = in_fill;
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
                rot_d   = in_rotate;
`else
                rot_d   = 1'b0;
`endif
                k_d     = KW'(SHAMT_W - 1);
                state_d = RUN;
            end
            RUN: begin
                data_d = stage;
                k_d    = (k_q == '0) ? k_q : k_q - 1'b1;
                if (k_q == '0) begin
                    out_data_d = stage;
                    state_d    = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            out_data_q <= '0;
            shamt_q    <= '0;
            fill_q     <= 1'b0;
            rot_q      <= 1'b0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
            shamt_q    <= shamt_d;
            fill_q     <= fill_d;
            rot_q      <= rot_d;
            k_q        <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: directed vector table plus stall and mid-run reset sequences.
module tb_shift_left_seq;
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic        in_fill = 1'b0;
    logic        in_rotate = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] last_res = '0;

    shift_left_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_fill(in_fill), .in_rotate(in_rotate),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        f;
        logic        r;
        logic [31:0] e;
        string       nm;
    } vec_t;

    vec_t v[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operand, scramble inputs while busy, then hold DONE for 'stall' cycles.
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic f, input logic r,
                         input logic [31:0] e, input string nm, input int stall);
        int lat;
        @(negedge clk);
        chk({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_data = d; in_shamt = s; in_fill = f; in_rotate = r; in_valid = 1'b1;
        @(posedge clk); #1;
        chk({nm, " run hold"}, out_data, last_res);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = 1'(($urandom));
            in_data = $urandom; in_shamt = 5'($urandom); in_fill = 1'($urandom); in_rotate = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({nm, " latency"}, lat, 32'd5);
        chk({nm, " data"}, out_data, e);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom);
            @(posedge clk); #1;
            chk({nm, " stall valid"}, {31'b0, out_valid}, 32'd1);
            chk({nm, " stall ready"}, {31'b0, in_ready}, 32'd0);
            chk({nm, " stall data"}, out_data, e);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " drained"}, {31'b0, out_valid}, 32'd0);
        chk({nm, " idle ready"}, {31'b0, in_ready}, 32'd1);
        chk({nm, " idle hold"}, out_data, e);
        last_res = e;
    endtask

    initial begin
        v[0] = '{32'h00000001, 5'd31, 1'b0, 1'b0, 32'h80000000, "one_sh31"};
        v[1] = '{32'h12345678, 5'd4,  1'b1, 1'b0, 32'h2345678F, "fill_sh4"};
        v[2] = '{32'hDEADBEEF, 5'd0,  1'b1, 1'b0, 32'hDEADBEEF, "sh0"};
        v[3] = '{32'h80000001, 5'd1,  1'b0, 1'b1, ROT ? 32'h00000003 : 32'h00000002, "rot_sh1"};
        v[4] = '{32'h00000002, 5'd31, 1'b1, 1'b0, 32'h7FFFFFFF, "fill_sh31"};
        v[5] = '{32'h000000FF, 5'd8,  1'b0, 1'b0, 32'h0000FF00, "sh8"};
        v[6] = '{32'hA5A5A5A5, 5'd16, 1'b1, 1'b0, 32'hA5A5FFFF, "fill_sh16"};
        v[7] = '{32'h12345678, 5'd8,  1'b1, 1'b1, ROT ? 32'h34567812 : 32'h345678FF, "rot_sh8"};
        v[8] = '{32'hF0000000, 5'd31, 1'b0, 1'b1, ROT ? 32'h78000000 : 32'h00000000, "rot_sh31"};

        #2;
        chk("reset in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        foreach (v[i]) do_op(v[i].d, v[i].s, v[i].f, v[i].r, v[i].e, v[i].nm, 0);

        do_op(32'h0000000F, 5'd4, 1'b0, 1'b0, 32'h000000F0, "stall", 3);

        // Abort mid-run: two edges after acceptance the stage index is 2.
        @(negedge clk);
        in_data = 32'h0F0F0F0F; in_shamt = 5'd7; in_fill = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre-abort data", out_data, 32'h000000F0);
        rst = 1'b1;
        #1;
        chk("abort out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort out_data", out_data, 32'd0);
        chk("abort in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort no result", {31'b0, out_valid}, 32'd0);
        do_op(32'h000000FF, 5'd8, 1'b0, 1'b0, 32'h0000FF00, "post_reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
